// File: rtl/aemb_iwb_rsp.sv
// Instruction-side Wishbone responder: serves 32-bit fetches from an internal
// word memory with programmable wait states, misalign error and a preload port.
module aemb_iwb_rsp #(
   parameter int AW    = 10,
   parameter int WAIT  = 0,
   parameter int BSWAP = 0
) (
   input  logic          gclk,
   input  logic          grst,
   input  logic          iwb_stb_i,
   input  logic [AW+1:0] iwb_adr_i,
   output logic [31:0]   iwb_dat_o,
   output logic          iwb_ack_o,
   output logic          iwb_err_o,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_adr,
   input  logic [31:0]   ld_dat
);

   generate
      if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
         $error("aemb_iwb_rsp: WAIT must be 0..15");
      end
   endgenerate

   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0]   mem [2**AW];
   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic [AW-1:0] adr_q, rd_adr;
   logic          ack_nxt, err_nxt, rd_en;
   logic [31:0]   rd_word, rd_fmt;

   always_ff @(posedge gclk) begin
      if (ld_we) mem[ld_adr] <= ld_dat;
   end

   // Read is combinational off the array and registered into dat_o, so a
   // same-edge load-port write is seen only by the next fetch.
   assign rd_word = mem[rd_adr];
   assign rd_fmt  = (BSWAP != 0) ? {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]}
                                 : rd_word;

   always_ff @(posedge gclk) begin
      if (state == S_IDLE && iwb_stb_i) adr_q <= iwb_adr_i[AW+1:2];
   end

   always_ff @(posedge gclk) begin
      if (grst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         iwb_ack_o <= 1'b0;
         iwb_err_o <= 1'b0;
         iwb_dat_o <= 32'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         iwb_ack_o <= ack_nxt;
         iwb_err_o <= err_nxt;
         if (rd_en)        iwb_dat_o <= rd_fmt;
         else if (err_nxt) iwb_dat_o <= 32'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      rd_en     = 1'b0;
      rd_adr    = adr_q;
      case (state)
         S_IDLE: begin
            rd_adr = iwb_adr_i[AW+1:2];
            if (iwb_stb_i) begin
               if (iwb_adr_i[1:0] != 2'b00) begin
                  err_nxt   = 1'b1;
                  state_nxt = S_RESP;
               end else if (WAIT == 0) begin
                  rd_en     = 1'b1;
                  ack_nxt   = 1'b1;
                  state_nxt = S_RESP;
               end else begin
                  cnt_nxt   = WAIT_CNT;
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!iwb_stb_i) begin
               state_nxt = S_IDLE;
            end else begin
               // Read as the counter reaches zero so WAIT lasts exactly WAIT cycles.
               cnt_nxt = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rd_en     = 1'b1;
                  ack_nxt   = 1'b1;
                  state_nxt = S_RESP;
               end
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
